// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready on both sides.
// Shift levels are spread evenly over PIPE_STAGES registered stages.
module shift_pipe #(
  parameter int WIDTH       = 32,
  parameter int SHW         = $clog2(WIDTH),
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b11;

  logic [PIPE_STAGES-1:0] vld_p;
  logic [WIDTH-1:0]       dat_p  [PIPE_STAGES];
  logic [SHW-1:0]         amt_p  [PIPE_STAGES];
  logic [1:0]             mode_p [PIPE_STAGES];
  logic                   zero_p;

  logic [PIPE_STAGES-1:0] src_vld;
  logic [WIDTH-1:0]       src_dat  [PIPE_STAGES];
  logic [SHW-1:0]         src_amt  [PIPE_STAGES];
  logic [1:0]             src_mode [PIPE_STAGES];
  logic [WIDTH-1:0]       nxt_dat  [PIPE_STAGES];
  logic [PIPE_STAGES:0]   load;

  // One shift level: moves by 2^lvl. SRA keeps replicating the original sign
  // because every earlier level already preserved the MSB.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       mode,
                                                   input int               lvl);
    logic signed [WIDTH-1:0] ds;
    int                      sh;
    sh = 1 << lvl;
    ds = d;
    case (mode)
      MODE_SLL: return d << sh;
      MODE_SRL: return d >> sh;
      MODE_SRA: return ds >>> sh;
      default:  return (d << sh) | (d >> (WIDTH - sh));
    endcase
  endfunction

  function automatic int stage_of(input int lvl);
    return (lvl * PIPE_STAGES) / SHW;
  endfunction

  always_comb begin
    src_vld[0]  = in_valid;
    src_dat[0]  = in_data;
    src_amt[0]  = in_amt;
    src_mode[0] = in_mode;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      src_vld[k]  = vld_p[k-1];
      src_dat[k]  = dat_p[k-1];
      src_amt[k]  = amt_p[k-1];
      src_mode[k] = mode_p[k-1];
    end
  end

  always_comb begin : level_eval
    logic [WIDTH-1:0] d;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      d = src_dat[k];
      for (int i = 0; i < SHW; i++) begin
        if (stage_of(i) == k && src_amt[k][i])
          d = shift_level(d, src_mode[k], i);
      end
      nxt_dat[k] = d;
    end
  end

  // Ready ripples back from the output: a stage may load if it is empty or
  // its successor is loading this cycle, so a full pipe still streams.
  always_comb begin : load_chain
    logic ld;
    load = '0;
    ld   = out_ready;
    load[PIPE_STAGES] = ld;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      ld      = !vld_p[k] | ld;
      load[k] = ld;
    end
  end

  assign in_ready = load[0];

  // Stage registers p0..p(PIPE_STAGES-1); data only moves on a valid load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p  <= '0;
      zero_p <= 1'b0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        dat_p[k]  <= '0;
        amt_p[k]  <= '0;
        mode_p[k] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (load[k])
          vld_p[k] <= src_vld[k];
        if (load[k] && src_vld[k]) begin
          dat_p[k]  <= nxt_dat[k];
          amt_p[k]  <= src_amt[k];
          mode_p[k] <= src_mode[k];
        end
      end
      if (load[PIPE_STAGES-1] && src_vld[PIPE_STAGES-1])
        zero_p <= ~|nxt_dat[PIPE_STAGES-1];
    end
  end

  assign out_valid = vld_p[PIPE_STAGES-1];
  assign out_data  = dat_p[PIPE_STAGES-1];
  assign out_zero  = zero_p;

endmodule
